// File: rtl/heap_arb_pkg.sv
// Shared types and constants for the heap queue arbiter.
// Record layout: key in bits REC_W-1:16, payload tag below.
package heap_arb_pkg;

    // IDLE: arbitrate | ISSUE: strobe queue | CAPT: capture pop | WAIT: settle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam int REC_W_DEF = 48;
    localparam int KEY_LSB   = 16;
    localparam int KEY_MSB   = REC_W_DEF - 1;
    localparam int ID_W      = 3;

endpackage

// File: rtl/heap_arb_if.sv
// Strobe/record bus between the arbiter (master) and the heap queue (slave).
interface heap_arb_if
    import heap_arb_pkg::*;
#(
    parameter int REC_W = REC_W_DEF
) ();

    logic             q_push;
    logic             q_pop;
    logic [REC_W-1:0] q_push_record;
    logic             q_full;
    logic             q_empty;
    logic             q_min_valid;
    logic [REC_W-1:0] q_pop_record;

    modport master (
        output q_push, q_pop, q_push_record,
        input  q_full, q_empty, q_min_valid, q_pop_record
    );

    modport slave (
        input  q_push, q_pop, q_push_record,
        output q_full, q_empty, q_min_valid, q_pop_record
    );

endinterface

// File: rtl/heap_arb_rr_arbiter.sv
// Round-robin pick: first eligible requester at or after the pointer, one-hot out.
module rr_arbiter
    import heap_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && (i == (int'(ptr_i) + off) % N_REQ) && elig_i[i]) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/heap_arb.sv
// Arbitrates N_REQ push/pop requesters onto a single heap queue, one op at a time,
// waiting for the queue to settle between operations.
module heap_arb
    import heap_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int REC_W    = REC_W_DEF,
    parameter int WAIT_MAX = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_push,
    input  logic [N_REQ-1:0]       req_pop,
    input  logic [N_REQ*REC_W-1:0] req_record,
    output logic [N_REQ-1:0]       req_ack,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [REC_W-1:0]       rsp_data,
    heap_arb_if.master             q,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_q;
    logic               op_pop_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   req_ack_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [REC_W-1:0]   rsp_data_q;
    logic               q_push_q;
    logic               q_pop_q;
    logic [REC_W-1:0]   q_push_record_q;
    logic               err_q;

    logic [N_REQ-1:0]   elig_d;
    logic [N_REQ-1:0]   grant_d;
    logic [ID_W-1:0]    gnt_d;
    logic [ID_W-1:0]    ptr_d;
    logic               push_d;
    logic               pop_d;
    logic [REC_W-1:0]   rec_d;

    always_comb begin
        elig_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig_d[i] = ( req_push[i] && !req_pop[i] && !q.q_full) ||
                        (!req_push[i] &&  req_pop[i] && !q.q_empty) ||
                        ( req_push[i] &&  req_pop[i] && !q.q_full && !q.q_empty);
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .elig_i  (elig_d),
        .ptr_i   (ptr_q),
        .grant_o (grant_d)
    );

    always_comb begin
        gnt_d  = '0;
        ptr_d  = ptr_q;
        push_d = 1'b0;
        pop_d  = 1'b0;
        rec_d  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_d[i]) begin
                gnt_d  = ID_W'(i);
                ptr_d  = ID_W'((i + 1) % N_REQ);
                push_d = req_push[i];
                pop_d  = req_pop[i];
                rec_d  = req_record[i*REC_W +: REC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            gnt_q           <= '0;
            op_pop_q        <= 1'b0;
            cnt_q           <= '0;
            req_ack_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_data_q      <= '0;
            q_push_q        <= 1'b0;
            q_pop_q         <= 1'b0;
            q_push_record_q <= '0;
            err_q           <= 1'b0;
        end else begin
            req_ack_q   <= '0;
            rsp_valid_q <= 1'b0;
            q_push_q    <= 1'b0;
            q_pop_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|grant_d) begin
                        gnt_q           <= gnt_d;
                        ptr_q           <= ptr_d;
                        op_pop_q        <= pop_d;
                        q_push_q        <= push_d;
                        q_pop_q         <= pop_d;
                        q_push_record_q <= rec_d;
                        req_ack_q       <= grant_d;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_CAPT;
                S_CAPT: begin
                    if (op_pop_q) begin
                        rsp_data_q  <= q.q_pop_record;
                        rsp_id_q    <= gnt_q;
                        rsp_valid_q <= 1'b1;
                    end
                    cnt_q   <= CNT_W'(WAIT_MAX - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Terminal count reached in the WAIT_MAX-th settle cycle.
                    if (q.q_min_valid || q.q_empty) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack         = req_ack_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_data        = rsp_data_q;
    assign q.q_push        = q_push_q;
    assign q.q_pop         = q_pop_q;
    assign q.q_push_record = q_push_record_q;
    assign busy            = (state_q != S_IDLE);
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_heap_arb.sv
// Self-checking bench for heap_arb with a behavioural sorted-queue heap model.
module tb_heap_arb;
    import heap_arb_pkg::*;

    localparam int N    = 4;
    localparam int RW   = 48;
    localparam int WM   = 32;
    localparam int QCAP = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_push = '0;
    logic [N-1:0]    req_pop  = '0;
    logic [N*RW-1:0] req_record = '0;
    logic [N-1:0]    req_ack;
    logic            rsp_valid;
    logic [2:0]      rsp_id;
    logic [RW-1:0]   rsp_data;
    logic            busy;
    logic            err_timeout;

    heap_arb_if #(.REC_W(RW)) qi ();

    heap_arb #(.N_REQ(N), .REC_W(RW), .WAIT_MAX(WM)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_push    (req_push),
        .req_pop     (req_pop),
        .req_record  (req_record),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .q           (qi),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] qmem[$];
    int            settle = 0;
    bit            stall  = 1'b0;

    function automatic logic [31:0] key_of(logic [RW-1:0] r);
        return r[RW-1:16];
    endfunction

    function automatic logic [RW-1:0] mkrec(logic [31:0] k, logic [15:0] t);
        return {k, t};
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int exp_grant(logic [N-1:0] p, logic [N-1:0] o,
                                     logic full, logic empty, int ptr);
        for (int off = 0; off < N; off++) begin
            int i;
            bit ok;
            i  = (ptr + off) % N;
            ok = (p[i] && !o[i] && !full) || (!p[i] && o[i] && !empty) ||
                 (p[i] && o[i] && !full && !empty);
            if (ok) return i;
        end
        return -1;
    endfunction

    // Heap queue model: kept sorted by key, popped record shown the cycle after q_pop.
    always @(posedge clk) begin
        int p;
        if (qi.q_pop && qmem.size() > 0) begin
            qi.q_pop_record <= qmem[0];
            void'(qmem.pop_front());
        end
        if (qi.q_push) begin
            p = qmem.size();
            for (int i = 0; i < qmem.size(); i++) begin
                if (key_of(qi.q_push_record) < key_of(qmem[i])) begin
                    p = i;
                    break;
                end
            end
            qmem.insert(p, qi.q_push_record);
        end
        if (qi.q_push || qi.q_pop) settle = $urandom_range(1, 4);
        else if (settle > 0) settle = settle - 1;
        qi.q_empty     <= (qmem.size() == 0);
        qi.q_full      <= (qmem.size() >= QCAP);
        qi.q_min_valid <= !stall && (settle == 0) && (qmem.size() > 0);
    end

    task automatic do_reset();
        rst      = 1'b1;
        req_push = '0;
        req_pop  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (qi.q_push || qi.q_pop) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [63+RW+RW:0] all_out;
        stall = 1'b0;
        qmem.delete();
        do_reset();
        all_out = {req_ack, rsp_valid, rsp_id, rsp_data, qi.q_push, qi.q_pop,
                   qi.q_push_record, err_timeout};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_push_single();
        int npush = 0, nrsp = 0, stray = 0;
        qmem.delete();
        do_reset();
        req_record[0 +: RW] = 48'h0000_1234_0000;
        req_push[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (qi.q_push) begin
                npush++;
                checks++;
                if (req_ack !== 4'b0001 || qi.q_pop !== 1'b0 ||
                    qi.q_push_record !== 48'h0000_1234_0000) begin
                    errors++;
                    $display("FAIL push_single_issue ack=%b pop=%b rec=%h want 0001 0 000012340000",
                             req_ack, qi.q_pop, qi.q_push_record);
                end
                req_push[0] = 1'b0;
            end else if (req_ack !== '0) stray++;
            if (rsp_valid) nrsp++;
        end
        checks++;
        if (npush != 1 || nrsp != 0 || stray != 0) begin
            errors++;
            $display("FAIL push_single_count push=%0d rsp=%0d stray_ack=%0d want 1 0 0",
                     npush, nrsp, stray);
        end
    endtask

    task automatic test_pop_min();
        bit ok;
        qmem.delete();
        qmem.push_back(mkrec(32'd5, 16'h5555));
        qmem.push_back(mkrec(32'd9, 16'h9999));
        do_reset();
        req_pop[2] = 1'b1;
        wait_strobe(ok);
        checks++;
        if (!ok || qi.q_pop !== 1'b1 || qi.q_push !== 1'b0 || req_ack !== 4'b0100) begin
            errors++;
            $display("FAIL pop_min_issue ok=%b pop=%b push=%b ack=%b want 1 1 0 0100",
                     ok, qi.q_pop, qi.q_push, req_ack);
        end
        req_pop[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_min_early got rsp_valid=%b want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_data !== mkrec(32'd5, 16'h5555)) begin
            errors++;
            $display("FAIL pop_min_rsp valid=%b id=%0d data=%h want 1 2 %h",
                     rsp_valid, rsp_id, rsp_data, mkrec(32'd5, 16'h5555));
        end
    endtask

    task automatic test_all_push();
        int order[4];
        int n = 0, last = -100, gapbad = 0, g;
        qmem.delete();
        do_reset();
        for (int i = 0; i < N; i++) begin
            order[i] = -1;
            req_record[i*RW +: RW] = mkrec(32'(20 + i), 16'(i));
        end
        req_push = '1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (qi.q_push) begin
                g = idx_of(req_ack);
                if (n < 4) order[n] = g;
                n++;
                if (k - last < 4) gapbad++;
                last = k;
                if (g >= 0) req_push[g] = 1'b0;
            end
        end
        checks++;
        if (n != 4 || gapbad != 0) begin
            errors++;
            $display("FAIL all_push_count grants=%0d close_gaps=%0d want 4 0", n, gapbad);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != i) begin
                errors++;
                $display("FAIL all_push_order slot %0d got %0d want %0d", i, order[i], i);
            end
        end
    endtask

    task automatic test_pop_blocked();
        int nstrobe = 0, n = 0, nrsp = 0;
        int ack_id[2];
        bit ack_push[2], ack_pop[2];
        logic [2:0]    rid = '0;
        logic [RW-1:0] rdat = '0;
        qmem.delete();
        do_reset();
        req_pop[1] = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (qi.q_push || qi.q_pop || req_ack !== '0) nstrobe++;
        end
        checks++;
        if (nstrobe != 0) begin
            errors++;
            $display("FAIL pop_blocked_idle got %0d strobes want 0", nstrobe);
        end
        req_record[3*RW +: RW] = mkrec(32'd77, 16'hBEEF);
        req_push[3] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ack !== '0) begin
                if (n < 2) begin
                    ack_id[n]   = idx_of(req_ack);
                    ack_push[n] = qi.q_push;
                    ack_pop[n]  = qi.q_pop;
                end
                n++;
                if (req_ack[3]) req_push[3] = 1'b0;
                if (req_ack[1]) req_pop[1]  = 1'b0;
            end
            if (rsp_valid) begin
                nrsp++;
                rid  = rsp_id;
                rdat = rsp_data;
            end
        end
        checks++;
        if (n != 2 || ack_id[0] != 3 || !ack_push[0] || ack_pop[0] ||
            ack_id[1] != 1 || ack_push[1] || !ack_pop[1]) begin
            errors++;
            $display("FAIL pop_blocked_order n=%0d first=%0d/%b%b second=%0d/%b%b want 2 3/10 1/01",
                     n, ack_id[0], ack_push[0], ack_pop[0], ack_id[1], ack_push[1], ack_pop[1]);
        end
        checks++;
        if (nrsp != 1 || rid !== 3'd1 || rdat !== mkrec(32'd77, 16'hBEEF)) begin
            errors++;
            $display("FAIL pop_blocked_rsp n=%0d id=%0d data=%h want 1 1 %h",
                     nrsp, rid, rdat, mkrec(32'd77, 16'hBEEF));
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int early = 0;
        qmem.delete();
        do_reset();
        stall = 1'b1;
        req_record[0 +: RW] = mkrec(32'd3, 16'h0003);
        req_push[0] = 1'b1;
        wait_strobe(ok);
        req_push[0] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_issue got no strobe want push");
        end
        for (int k = 1; k <= WM + 2; k++) begin
            @(negedge clk);
            if (k <= WM + 1 && err_timeout) early++;
        end
        checks++;
        if (early != 0 || err_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set early=%0d err=%b busy=%b want 0 1 0", early, err_timeout, busy);
        end
        stall = 1'b0;
        req_record[RW +: RW] = mkrec(32'd4, 16'h0004);
        req_push[1] = 1'b1;
        wait_strobe(ok);
        req_push[1] = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky ok=%b err=%b want 1 1", ok, err_timeout);
        end
        do_reset();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got %b want 0", err_timeout);
        end
    endtask

    task automatic test_reset_capt();
        bit ok;
        int nrsp = 0, g = -1;
        logic [63+RW+RW:0] all_out;
        qmem.delete();
        qmem.push_back(mkrec(32'd8, 16'h0008));
        qmem.push_back(mkrec(32'd12, 16'h000C));
        do_reset();
        req_pop[1] = 1'b1;
        wait_strobe(ok);
        req_pop[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        all_out = {req_ack, rsp_valid, rsp_id, rsp_data, qi.q_push, qi.q_pop,
                   qi.q_push_record, err_timeout};
        checks++;
        if (!ok || all_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_capt_outputs ok=%b out=%h busy=%b want 1 0 0", ok, all_out, busy);
        end
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        checks++;
        if (nrsp != 0) begin
            errors++;
            $display("FAIL reset_capt_rsp got %0d pulses want 0", nrsp);
        end
        req_record[0 +: RW]    = mkrec(32'd1, 16'h0001);
        req_record[2*RW +: RW] = mkrec(32'd2, 16'h0002);
        req_push[0] = 1'b1;
        req_push[2] = 1'b1;
        wait_strobe(ok);
        if (ok) g = idx_of(req_ack);
        req_push[g < 0 ? 0 : g] = 1'b0;
        checks++;
        if (g != 0) begin
            errors++;
            $display("FAIL reset_capt_pointer first grant %0d want 0", g);
        end
        req_push = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0]  pend_push = '0, pend_pop = '0;
        logic [RW-1:0] rec[N];
        int            age[N];
        logic [N-1:0]  prev_push = '0, prev_pop = '0;
        logic [RW-1:0] prev_rec[N];
        logic          prev_full = 1'b0, prev_empty = 1'b1;
        int            ptr_m = 0, last = -100, nacks = 0, g, e;
        int            due_q[$];
        int            id_q[$];
        logic [RW-1:0] data_q[$];
        bit            exp_rsp;
        qmem.delete();
        qmem.push_back(mkrec(32'd10, 16'h000A));
        qmem.push_back(mkrec(32'd30, 16'h001E));
        do_reset();
        for (int i = 0; i < N; i++) begin
            rec[i] = '0;
            prev_rec[i] = '0;
            age[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (req_ack !== '0) begin
                nacks++;
                g = idx_of(req_ack);
                e = exp_grant(prev_push, prev_pop, prev_full, prev_empty, ptr_m);
                checks++;
                if (!$onehot(req_ack) || g != e) begin
                    errors++;
                    $display("FAIL rand_grant cyc %0d ack=%b want index %0d", cyc, req_ack, e);
                end
                if (g >= 0) begin
                    checks++;
                    if (qi.q_push !== prev_push[g] || qi.q_pop !== prev_pop[g] ||
                        (prev_push[g] && qi.q_push_record !== prev_rec[g])) begin
                        errors++;
                        $display("FAIL rand_ops cyc %0d push=%b pop=%b rec=%h want %b %b %h",
                                 cyc, qi.q_push, qi.q_pop, qi.q_push_record,
                                 prev_push[g], prev_pop[g], prev_rec[g]);
                    end
                    if (qi.q_pop && qmem.size() > 0) begin
                        due_q.push_back(cyc + 2);
                        id_q.push_back(g);
                        data_q.push_back(qmem[0]);
                    end
                    pend_push[g] = 1'b0;
                    pend_pop[g]  = 1'b0;
                    age[g]       = 0;
                    ptr_m        = (g + 1) % N;
                end
                checks++;
                if (cyc - last < 4) begin
                    errors++;
                    $display("FAIL rand_spacing cyc %0d gap %0d want >= 4", cyc, cyc - last);
                end
                last = cyc;
            end else if (qi.q_push || qi.q_pop) begin
                checks++;
                errors++;
                $display("FAIL rand_strobe_no_ack cyc %0d push=%b pop=%b want no strobe",
                         cyc, qi.q_push, qi.q_pop);
            end
            exp_rsp = (due_q.size() > 0) && (due_q[0] == cyc);
            checks++;
            if (rsp_valid !== exp_rsp ||
                (exp_rsp && (rsp_id !== 3'(id_q[0]) || rsp_data !== data_q[0]))) begin
                errors++;
                $display("FAIL rand_rsp cyc %0d valid=%b id=%0d data=%h want %b %0d %h",
                         cyc, rsp_valid, rsp_id, rsp_data, exp_rsp,
                         exp_rsp ? id_q[0] : 0, exp_rsp ? data_q[0] : '0);
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                void'(id_q.pop_front());
                void'(data_q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (pend_push[i] || pend_pop[i]) begin
                    age[i]++;
                    if (age[i] > 500) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_starve requester %0d waited %0d cycles want <= 500", i, age[i]);
                        pend_push[i] = 1'b0;
                        pend_pop[i]  = 1'b0;
                        age[i]       = 0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    rec[i] = mkrec(32'($urandom_range(0, 50)), 16'($urandom_range(0, 65535)));
                    case (i == 0 ? 1 : i == 1 ? 0 : int'($urandom_range(0, 2)))
                        0:       pend_push[i] = 1'b1;
                        1:       pend_pop[i]  = 1'b1;
                        default: begin pend_push[i] = 1'b1; pend_pop[i] = 1'b1; end
                    endcase
                end
                req_record[i*RW +: RW] = rec[i];
                prev_rec[i] = rec[i];
            end
            req_push   = pend_push;
            req_pop    = pend_pop;
            prev_push  = pend_push;
            prev_pop   = pend_pop;
            prev_full  = qi.q_full;
            prev_empty = qi.q_empty;
        end
        checks++;
        if (nacks < 100 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rand_summary acks=%0d err=%b want >= 100 0", nacks, err_timeout);
        end
        req_push = '0;
        req_pop  = '0;
    endtask

    initial begin
        test_reset();
        test_push_single();
        test_pop_min();
        test_all_push();
        test_pop_blocked();
        test_timeout();
        test_reset_capt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
